// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter.
//   REG_ADDR_W / NUM_REGS : register-file addressing
//   DATA_W                : register-file data width
//   wb_sel_e              : which source owns the write port this cycle
//   wb_req_t              : one pending register write {rd, data}
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_MEM,
    WB_BUF,
    WB_ALU
  } wb_sel_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending ALU write-backs.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry
//   head       : current head entry (valid when !empty)
//   count      : number of stored entries (0..DEPTH)
//   full/empty : count==DEPTH / count==0
// Push and pop in the same cycle leave count unchanged. The caller never
// pushes when full, and never pops when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output wb_req_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/wb_write_arbiter.sv
// Write-back arbiter driving the register file's single write port.
//   clk, rst                  : clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data : in-order ALU write-back request
//   mem_issue/mem_issue_rd    : load issued, mark destination pending
//   mem_valid/mem_rd/mem_data : load response (never stalled)
//   stall                     : ALU buffer full, producer must hold
//   regWrite/RD/writeData     : registered write port (1-cycle latency)
//   busy_mask                 : outstanding-load scoreboard
//   err                       : sticky, response for a non-pending register
// Priority: load response > buffered ALU result > fresh ALU result.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int n     = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [n-1:0]          alu_data,
  input  logic                  mem_issue,
  input  logic [REG_ADDR_W-1:0] mem_issue_rd,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [n-1:0]          mem_data,
  output logic                  stall,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] RD,
  output logic [n-1:0]          writeData,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_sel_e          sel;
  wb_req_t          alu_req, buf_head;
  logic             buf_push, buf_pop, buf_full, buf_empty;
  logic [CNT_W-1:0] buf_count;
  logic             alu_acc, mem_win;

  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [n-1:0]          data_q, data_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  err_q, err_d;

  assign alu_req = '{rd: alu_rd, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (alu_req),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Registered-state-only stall: acceptance can never overflow the buffer.
  assign stall   = (buf_count == CNT_W'(DEPTH));
  // rd==0 requests are accepted but produce no write.
  assign alu_acc = alu_valid && !buf_full && (alu_rd != '0);
  assign mem_win = mem_valid && (mem_rd != '0);

  always_comb begin
    sel        = WB_NONE;
    buf_push   = 1'b0;
    buf_pop    = 1'b0;
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    data_d     = data_q;

    if (mem_win)         sel = WB_MEM;
    else if (!buf_empty) sel = WB_BUF;
    else if (alu_acc)    sel = WB_ALU;

    // A fresh ALU result that does not go straight out joins the tail,
    // keeping ALU results in acceptance order.
    buf_push = alu_acc && (sel != WB_ALU);
    buf_pop  = (sel == WB_BUF);

    case (sel)
      WB_MEM: begin
        regwrite_d = 1'b1;
        rd_d       = mem_rd;
        data_d     = mem_data;
      end
      WB_BUF: begin
        regwrite_d = 1'b1;
        rd_d       = buf_head.rd;
        data_d     = buf_head.data;
      end
      WB_ALU: begin
        regwrite_d = 1'b1;
        rd_d       = alu_rd;
        data_d     = alu_data;
      end
      default: ;
    endcase
  end

  // Scoreboard: clear on response, then set on issue so a same-cycle
  // re-issue of the same register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (mem_win)                        busy_d[mem_rd]       = 1'b0;
    if (mem_issue && mem_issue_rd != '0) busy_d[mem_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    err_d = err_q | (mem_win && !busy_q[mem_rd]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign regWrite  = regwrite_q;
  assign RD        = rd_q;
  assign writeData = data_q;
  assign busy_mask = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_issue;
  logic [4:0]  mem_issue_rd;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        stall;
  logic        regWrite;
  logic [4:0]  RD;
  logic [31:0] writeData;
  logic [31:0] busy_mask;
  logic        err;

  always #5 clk = ~clk;

  wb_write_arbiter #(.n(32), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_issue    (mem_issue),
    .mem_issue_rd (mem_issue_rd),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .stall        (stall),
    .regWrite     (regWrite),
    .RD           (RD),
    .writeData    (writeData),
    .busy_mask    (busy_mask),
    .err          (err)
  );

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        iv;  logic [4:0] ird;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        rw;  logic [4:0] rd;  logic [31:0] wd;
    logic        st;  logic [31:0] busy; logic er;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic void addv(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic iv, input logic [4:0] ird,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic rw, input logic [4:0] rd, input logic [31:0] wd,
    input logic st, input logic [31:0] busy, input logic er);
    vecs.push_back('{av, ard, ad, iv, ird, mv, mrd, md, rw, rd, wd, st, busy, er});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ird,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_issue = iv; mem_issue_rd = ird;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   alu            issue     mem              expected rw/RD/wd        stall busy        err
    addv(1,5,32'hA5,    0,0,      0,0,0,           1,5,32'hA5,              0,32'h0,      0); // bypass
    addv(0,0,0,         0,0,      0,0,0,           0,5,32'hA5,              0,32'h0,      0); // hold
    addv(0,0,0,         1,7,      0,0,0,           0,5,32'hA5,              0,32'h80,     0);
    addv(1,3,32'h22,    0,0,      1,7,32'h11,      1,7,32'h11,              0,32'h0,      0); // mem wins
    addv(0,0,0,         0,0,      0,0,0,           1,3,32'h22,              0,32'h0,      0); // buffered
    addv(0,0,0,         0,0,      0,0,0,           0,3,32'h22,              0,32'h0,      0);
    addv(0,0,0,         1,10,     0,0,0,           0,3,32'h22,              0,32'h400,    0);
    addv(0,0,0,         1,11,     0,0,0,           0,3,32'h22,              0,32'hC00,    0);
    addv(0,0,0,         1,12,     0,0,0,           0,3,32'h22,              0,32'h1C00,   0);
    addv(1,1,32'h1,     0,0,      1,10,32'h100,    1,10,32'h100,            0,32'h1800,   0);
    addv(1,2,32'h2,     0,0,      1,11,32'h101,    1,11,32'h101,            1,32'h1000,   0); // full
    addv(1,13,32'h3,    0,0,      1,12,32'h102,    1,12,32'h102,            1,32'h0,      0); // ignored
    addv(1,13,32'h3,    0,0,      0,0,0,           1,1,32'h1,               0,32'h0,      0); // drain
    addv(1,13,32'h3,    0,0,      0,0,0,           1,2,32'h2,               0,32'h0,      0); // push+pop
    addv(0,0,0,         0,0,      0,0,0,           1,13,32'h3,              0,32'h0,      0);
    addv(0,0,0,         0,0,      0,0,0,           0,13,32'h3,              0,32'h0,      0);
    addv(1,0,32'hFF,    0,0,      1,0,32'hEE,      0,13,32'h3,              0,32'h0,      0); // rd 0
    addv(0,0,0,         0,0,      1,9,32'h99,      1,9,32'h99,              0,32'h0,      1); // err
    addv(0,0,0,         1,4,      1,4,32'h44,      1,4,32'h44,              0,32'h10,     1); // set wins
    addv(0,0,0,         0,0,      1,4,32'h45,      1,4,32'h45,              0,32'h0,      1);
    addv(0,0,0,         0,0,      0,0,0,           0,4,32'h45,              0,32'h0,      1);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("reset.regWrite", 32'(regWrite), 32'h0);
    chk("reset.RD", 32'(RD), 32'h0);
    chk("reset.writeData", writeData, 32'h0);
    chk("reset.busy_mask", busy_mask, 32'h0);
    chk("reset.err", 32'(err), 32'h0);
    chk("reset.stall", 32'(stall), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].iv, vecs[i].ird,
            vecs[i].mv, vecs[i].mrd, vecs[i].md);
      step();
      $display("vec %0d: regWrite=%0d RD=%0d writeData=0x%0h stall=%0d busy_mask=0x%0h err=%0d",
               i, regWrite, RD, writeData, stall, busy_mask, err);
      chk($sformatf("v%0d.regWrite", i), 32'(regWrite), 32'(vecs[i].rw));
      chk($sformatf("v%0d.RD", i), 32'(RD), 32'(vecs[i].rd));
      chk($sformatf("v%0d.writeData", i), writeData, vecs[i].wd);
      chk($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].st));
      chk($sformatf("v%0d.busy_mask", i), busy_mask, vecs[i].busy);
      chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].er));
    end

    // Fill the buffer with two entries and leave loads to x3, x7 pending,
    // then reset mid-cycle.
    drive(0, 0, 0, 1, 3, 0, 0, 0);          step();
    drive(0, 0, 0, 1, 7, 0, 0, 0);          step();
    drive(0, 0, 0, 1, 20, 0, 0, 0);         step();
    drive(0, 0, 0, 1, 21, 0, 0, 0);         step();
    drive(1, 5, 32'h55, 0, 0, 1, 20, 32'h20); step();
    drive(1, 6, 32'h66, 0, 0, 1, 21, 32'h21); step();
    $display("pre-reset: stall=%0d busy_mask=0x%0h regWrite=%0d RD=%0d", stall, busy_mask, regWrite, RD);
    chk("prerst.stall", 32'(stall), 32'h1);
    chk("prerst.busy_mask", busy_mask, 32'h88);
    chk("prerst.RD", 32'(RD), 32'd21);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: regWrite=%0d RD=%0d writeData=0x%0h busy_mask=0x%0h err=%0d stall=%0d",
             regWrite, RD, writeData, busy_mask, err, stall);
    chk("arst.regWrite", 32'(regWrite), 32'h0);
    chk("arst.RD", 32'(RD), 32'h0);
    chk("arst.writeData", writeData, 32'h0);
    chk("arst.busy_mask", busy_mask, 32'h0);
    chk("arst.err", 32'(err), 32'h0);
    chk("arst.stall", 32'(stall), 32'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      $display("post-reset %0d: regWrite=%0d RD=%0d stall=%0d", k, regWrite, RD, stall);
      chk($sformatf("postrst%0d.regWrite", k), 32'(regWrite), 32'h0);
      chk($sformatf("postrst%0d.RD", k), 32'(RD), 32'h0);
      chk($sformatf("postrst%0d.stall", k), 32'(stall), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
